// File: rtl/fmul_share_arb_pkg.sv
// fmul_share_arb_pkg: shared widths, FP32 defaults and response entry type for the fmul share arbiter
package fmul_share_arb_pkg;
    localparam int FFLAGS_W       = 5;
    localparam int RM_W           = 3;
    localparam int FP32_EXPWIDTH  = 8;
    localparam int FP32_PRECISION = 24;
    localparam int RSP_ID_W       = 8;

    typedef struct packed {
        logic [RSP_ID_W-1:0]                       id;
        logic [FP32_EXPWIDTH+FP32_PRECISION-1:0]   result;
        logic [FFLAGS_W-1:0]                       fflags;
    } rsp_entry_t;
endpackage

// File: rtl/fmul_share_rsp_fifo.sv
// fmul_share_rsp_fifo: synchronous response FIFO with count-based full/empty, async active-low reset
module fmul_share_rsp_fifo
    import fmul_share_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, wr_en, rd_en;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // storage array, written at the tail
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/fmul_share_arb.sv
// fmul_share_arb: round-robin share of one pipelined FP multiplier; optional FMUL_SHARE_ARB_BYPASS_EN lets results skip an empty FIFO
module fmul_share_arb
    import fmul_share_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FMUL_LAT   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int EXPWIDTH   = FP32_EXPWIDTH,
    parameter int PRECISION  = FP32_PRECISION,
    localparam int W         = EXPWIDTH + PRECISION,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*W-1:0]    req_a_i,
    input  logic [NUM_REQ*W-1:0]    req_b_i,
    input  logic [NUM_REQ*RM_W-1:0] req_rm_i,
    output logic                    fmul_valid_o,
    output logic [W-1:0]            fmul_a_o,
    output logic [W-1:0]            fmul_b_o,
    output logic [RM_W-1:0]         fmul_rm_o,
    input  logic [W-1:0]            fmul_result_i,
    input  logic [FFLAGS_W-1:0]     fmul_fflags_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [W-1:0]            rsp_result_o,
    output logic [FFLAGS_W-1:0]     rsp_fflags_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = ID_W + W + FFLAGS_W;

    logic [CW-1:0]   credit;
    logic [ID_W-1:0] rr_ptr, gnt_id, idx;
    logic            gnt_hit, accept, res_v, fifo_push, fifo_empty, rsp_pop;
    logic [FMUL_LAT:0] tag_v;
    logic [ID_W-1:0] tag_id [FMUL_LAT+1];
    logic [DW-1:0]   res_entry, fifo_dout, rsp_entry;

    // first valid requester at or after rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        gnt_hit = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid_i[idx]) begin
                gnt_hit = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign accept       = gnt_hit && (credit != '0);
    assign req_ready_o  = accept ? (NUM_REQ'(1) << gnt_id) : '0;
    assign fmul_valid_o = tag_v[0];

    // operand register feeding the multiplier; holds its value when nothing is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmul_a_o  <= '0;
            fmul_b_o  <= '0;
            fmul_rm_o <= '0;
        end else if (accept) begin
            fmul_a_o  <= req_a_i[int'(gnt_id)*W +: W];
            fmul_b_o  <= req_b_i[int'(gnt_id)*W +: W];
            fmul_rm_o <= req_rm_i[int'(gnt_id)*RM_W +: RM_W];
        end
    end

    // round-robin pointer and credit pool; an issue and a pop in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            credit <= CW'(FIFO_DEPTH);
        end else begin
            if (accept) rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            credit <= credit + CW'(rsp_pop) - CW'(accept);
        end
    end

    // valid/id shadow of the multiplier; stage 0 lines up with the operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i <= FMUL_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v     <= {tag_v[FMUL_LAT-1:0], accept};
            tag_id[0] <= gnt_id;
            for (int i = 1; i <= FMUL_LAT; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    assign res_v     = tag_v[FMUL_LAT];
    assign res_entry = {tag_id[FMUL_LAT], fmul_result_i, fmul_fflags_i};

`ifdef FMUL_SHARE_ARB_BYPASS_EN
    assign rsp_valid_o = !fifo_empty || res_v;
    assign rsp_entry   = fifo_empty ? res_entry : fifo_dout;
    assign fifo_push   = res_v && !(fifo_empty && rsp_ready_i);
`else
    assign rsp_valid_o = !fifo_empty;
    assign rsp_entry   = fifo_dout;
    assign fifo_push   = res_v;
`endif

    assign rsp_pop = rsp_valid_o && rsp_ready_i;
    assign {rsp_id_o, rsp_result_o, rsp_fflags_o} = rsp_valid_o ? rsp_entry : '0;

    fmul_share_rsp_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (res_entry),
        .pop   (rsp_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_fmul_share_arb.sv
// tb_fmul_share_arb: randomized self-checking bench with a queue-based reference model
module tb_fmul_share_arb;
    import fmul_share_arb_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int IDW   = 2;
`ifdef FMUL_SHARE_ARB_BYPASS_EN
    localparam int EXP_LAT = LAT + 1;
`else
    localparam int EXP_LAT = LAT + 2;
`endif

    logic              clk, rst_n;
    logic [N-1:0]      req_valid_i, req_ready_o;
    logic [N*W-1:0]    req_a_i, req_b_i;
    logic [N*3-1:0]    req_rm_i;
    logic              fmul_valid_o;
    logic [W-1:0]      fmul_a_o, fmul_b_o, fmul_result_i;
    logic [2:0]        fmul_rm_o;
    logic [4:0]        fmul_fflags_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [W-1:0]      rsp_result_o;
    logic [4:0]        rsp_fflags_o;

    fmul_share_arb #(.NUM_REQ(N), .FMUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i),
        .fmul_valid_o(fmul_valid_o), .fmul_a_o(fmul_a_o), .fmul_b_o(fmul_b_o), .fmul_rm_o(fmul_rm_o),
        .fmul_result_i(fmul_result_i), .fmul_fflags_i(fmul_fflags_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in multiplier: 1.0 * b returns b exactly, anything else a deterministic scramble
    function automatic logic [W-1:0] mul_res(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] rm);
        return (a == 32'h3F800000) ? b : ((a ^ {b[15:0], b[31:16]}) + {29'd0, rm});
    endfunction

    function automatic logic [4:0] mul_flg(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] rm);
        return a[4:0] ^ b[4:0] ^ {2'b00, rm};
    endfunction

    logic [W-1:0] mres [LAT];
    logic [4:0]   mflg [LAT];

    always @(posedge clk) begin
        mres[0] <= mul_res(fmul_a_o, fmul_b_o, fmul_rm_o);
        mflg[0] <= mul_flg(fmul_a_o, fmul_b_o, fmul_rm_o);
        for (int k = 1; k < LAT; k++) begin
            mres[k] <= mres[k-1];
            mflg[k] <= mflg[k-1];
        end
    end

    assign fmul_result_i = mres[LAT-1];
    assign fmul_fflags_i = mflg[LAT-1];

    int checks = 0, errors = 0;
    int cyc = 0, rr = 0, acc_cnt = 0, rsp_cnt = 0;
    int last_acc_cyc = -1, last_rsp_cyc = -1;
    logic [W-1:0] last_rsp_res;
    logic [4:0]   last_rsp_flg;
    rsp_entry_t q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: evaluate the model at the falling edge, then return just after the rising edge
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            int g;
            logic [N-1:0] er;
            rsp_entry_t e;
            g  = -1;
            er = '0;
            if (q.size() < DEPTH)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid_i[(rr + k) % N]) g = (rr + k) % N;
            if (g >= 0) er[g] = 1'b1;
            check("ready", req_ready_o, er);
            if (rsp_valid_o) begin
                if (q.size() == 0) check("rsp_unexpected", rsp_valid_o, 1'b0);
                else begin
                    check("rsp_id", rsp_id_o, q[0].id);
                    check("rsp_result", rsp_result_o, q[0].result);
                    check("rsp_fflags", rsp_fflags_o, q[0].fflags);
                    if (rsp_ready_i) begin
                        void'(q.pop_front());
                        rsp_cnt++;
                        last_rsp_cyc = cyc;
                        last_rsp_res = rsp_result_o;
                        last_rsp_flg = rsp_fflags_o;
                    end
                end
            end
            if (g >= 0) begin
                e.id     = RSP_ID_W'(g);
                e.result = mul_res(req_a_i[g*W +: W], req_b_i[g*W +: W], req_rm_i[g*3 +: 3]);
                e.fflags = mul_flg(req_a_i[g*W +: W], req_b_i[g*W +: W], req_rm_i[g*3 +: 3]);
                q.push_back(e);
                rr = (g + 1) % N;
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (dut.u_fifo.push) check("fifo_overflow", dut.u_fifo.full, 1'b0);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a_i[i*W +: W] = $urandom;
            req_b_i[i*W +: W] = $urandom;
        end
        req_rm_i = 12'($urandom);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_fvalid"}, fmul_valid_o, 1'b0);
        check({tag, "_fa"}, fmul_a_o, 0);
        check({tag, "_fb"}, fmul_b_o, 0);
        check({tag, "_frm"}, fmul_rm_o, 0);
        check({tag, "_rvalid"}, rsp_valid_o, 1'b0);
        check({tag, "_rid"}, rsp_id_o, 0);
        check({tag, "_rres"}, rsp_result_o, 0);
        check({tag, "_rflg"}, rsp_fflags_o, 0);
    endtask

    initial begin
        int a0, t0;
        rst_n = 1'b1;
        req_valid_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        req_rm_i = '0;
        rsp_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 reset_checks("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // single op from requester 2: 1.0 * 2.0
        rand_ops();
        req_a_i[2*W +: W] = 32'h3F800000;
        req_b_i[2*W +: W] = 32'h40000000;
        req_rm_i[2*3 +: 3] = 3'd0;
        req_valid_i = 4'b0100;
        rsp_ready_i = 1'b1;
        a0 = rsp_cnt;
        step();
        t0 = last_acc_cyc;
        req_valid_i = '0;
        for (int i = 0; i < 15 && rsp_cnt == a0; i++) step();
        check("single_latency", last_rsp_cyc - t0, EXP_LAT);
        check("single_result", last_rsp_res, 32'h40000000);
        check("single_fflags", last_rsp_flg, 5'd0);

        // fairness: everyone requesting, downstream always ready
        req_valid_i = '1;
        for (int i = 0; i < 16; i++) begin
            rand_ops();
            step();
        end
        req_valid_i = '0;
        for (int i = 0; i < 10; i++) step();

        // backpressure: credits run out after exactly DEPTH accepts
        rsp_ready_i = 1'b0;
        req_valid_i = '1;
        a0 = acc_cnt;
        for (int i = 0; i < 15; i++) begin
            rand_ops();
            step();
        end
        check("bp_accepts", acc_cnt - a0, DEPTH);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) step();
        req_valid_i = '0;
        for (int i = 0; i < 10; i++) step();

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid_i = N'($urandom);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end

        // reset with work in flight, then restart from requester 0
        req_valid_i = '1;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
        end
        rst_n = 1'b0;
        #1 reset_checks("midreset");
        q.delete();
        rr = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step();
        end
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            req_valid_i = N'($urandom);
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end

        // drain everything still outstanding within a bounded number of cycles
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) step();
        check("drain_empty", q.size(), 0);
        step();
        check("idle_rvalid", rsp_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
